// File: rtl/sar_adc_controller_pkg.sv
// Shared types and constants for the SAR ADC controller.
// sar_state_t is the controller FSM encoding; SAR_WIDTH and
// SAR_SETTLE_CYCLES are the default resolution and RC-filter settle time.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } sar_state_t;

    localparam int SAR_WIDTH = 8;

    // 5 ms at 100 MHz: time the RC filter needs after each DAC code change.
    localparam int SAR_SETTLE_CYCLES = 500_000;

endpackage

// File: rtl/sar_adc_controller_pwm_dac.sv
// PWM DAC for the SAR loop: a free-running WIDTH-bit counter compared
// against the duty code. The period is 2^WIDTH clk. Duty 0 gives a
// constant low output; full-scale duty is high for all but one count.
module sar_pwm_dac #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm_out
);

    logic [WIDTH-1:0] pwm_cnt;

    // Counter wraps naturally from all-ones to zero; output is registered.
    always_ff @(posedge clk) begin
        // NOTE: state is only ever written with <= so every flop samples
        // the pre-edge values of its inputs, independent of block ordering.
        if (reset) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + WIDTH'(1);
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/sar_adc_controller.sv
// Successive-approximation ADC controller. Drives a PWM DAC whose filtered
// output feeds an external comparator, then binary-searches the comparator
// result over WIDTH steps, each preceded by SETTLE_CYCLES of filter settling.
// Optional build macro SAR_CMP_SYNC_EN: passes pwm_compare through a
// two-flop synchronizer and extends each settle phase by two cycles so the
// synchronized value reflects the settled code.
module sar_adc_controller
    import sar_pkg::*;
#(
    parameter int WIDTH         = SAR_WIDTH,
    parameter int SETTLE_CYCLES = SAR_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_compare,
    output logic             pwm_out,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] adc_result,
    output logic             conversion_done,
    output logic             busy
);

`ifdef SAR_CMP_SYNC_EN
    localparam int SETTLE_EXTRA = 2;
`else
    localparam int SETTLE_EXTRA = 0;
`endif

    localparam int SETTLE_TOTAL = SETTLE_CYCLES + SETTLE_EXTRA;
    localparam int CNT_W        = (SETTLE_TOTAL > 1) ? $clog2(SETTLE_TOTAL) : 1;
    localparam int IDX_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TOTAL - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE    = WIDTH'(1) << (WIDTH - 1);

    sar_state_t       state;
    logic [CNT_W-1:0] settle_cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] bit_idx_dn;
    logic             cmp_bit;
    logic [WIDTH-1:0] kept_code;
    logic [WIDTH-1:0] next_trial;

`ifdef SAR_CMP_SYNC_EN
    logic [1:0] cmp_sync;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_sync <= 2'b00;
        end else begin
            cmp_sync <= {cmp_sync[0], pwm_compare};
        end
    end

    assign cmp_bit = cmp_sync[1];
`else
    assign cmp_bit = pwm_compare;
`endif

    assign bit_idx_dn = bit_idx - IDX_W'(1);

    // Resolve the current bit from the comparator and form the next trial code.
    always_comb begin
        // NOTE: every output gets a default before any conditional update,
        // so no path leaves a variable unassigned and no latch is inferred.
        kept_code  = dac_code;
        if (!cmp_bit) begin
            kept_code[bit_idx] = 1'b0;
        end
        next_trial = kept_code;
        if (bit_idx != '0) begin
            next_trial[bit_idx_dn] = 1'b1;
        end
    end

    // Conversion FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            dac_code        <= '0;
            adc_result      <= '0;
            conversion_done <= 1'b0;
            busy            <= 1'b0;
            settle_cnt      <= '0;
            bit_idx         <= IDX_MSB;
        end else begin
            conversion_done <= 1'b0;
            case (state)
                IDLE: begin
                    // dac_code is held here so the PWM keeps driving the last result.
                    if (enable) begin
                        dac_code   <= MSB_CODE;
                        bit_idx    <= IDX_MSB;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + CNT_W'(1);
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (bit_idx == '0) begin
                        dac_code <= kept_code;
                        state    <= DONE;
                    end else begin
                        dac_code   <= next_trial;
                        bit_idx    <= bit_idx_dn;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                DONE: begin
                    adc_result      <= dac_code;
                    conversion_done <= 1'b1;
                    busy            <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    sar_pwm_dac #(
        .WIDTH (WIDTH)
    ) u_pwm_dac (
        .clk     (clk),
        .reset   (reset),
        .duty    (dac_code),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_sar_adc_controller.sv
// Self-checking bench for sar_adc_controller with SETTLE_CYCLES=4.
// The comparator is modelled as (target >= dac_code). Expected conversion
// results are queued when a conversion is launched; a monitor pops and
// compares on every conversion_done pulse.
module tb_sar_adc_controller;

    localparam int W      = 8;
    localparam int SETTLE = 4;
`ifdef SAR_CMP_SYNC_EN
    localparam int EXTRA  = 2;
`else
    localparam int EXTRA  = 0;
`endif
    localparam int STEP   = SETTLE + 1 + EXTRA;
    localparam int LAT    = 1 + W * STEP;
    localparam int PERIOD = LAT + 1;
    localparam int BOUND  = 200;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         pwm_compare;
    logic         pwm_out;
    logic [W-1:0] dac_code;
    logic [W-1:0] adc_result;
    logic         conversion_done;
    logic         busy;
    logic [W-1:0] target = 8'h00;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           done_seen = 0;
    logic [W-1:0] sb[$];

    assign pwm_compare = (target >= dac_code);

    sar_adc_controller #(
        .WIDTH         (W),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .pwm_compare     (pwm_compare),
        .pwm_out         (pwm_out),
        .dac_code        (dac_code),
        .adc_result      (adc_result),
        .conversion_done (conversion_done),
        .busy            (busy)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    initial forever begin
        logic [W-1:0] exp_res;
        @(negedge clk);
        if (conversion_done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_res = sb.pop_front();
                check("adc_result", 32'(adc_result), 32'(exp_res));
            end
        end
    end

    // Wait (bounded) for the next done pulse; returns the cycle it appeared in.
    task automatic wait_done(input string name, output int t);
        t = -1;
        for (int n = 0; n < BOUND; n++) begin
            @(posedge clk);
            #1;
            if (conversion_done === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Launch one conversion with a single-cycle enable; t0 is the sampling edge.
    task automatic pulse_enable(input logic [W-1:0] tgt, output int t0);
        @(negedge clk);
        target = tgt;
        sb.push_back(tgt);
        enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        enable = 1'b0;
    endtask

    initial begin
        logic [W-1:0] seq[W];
        int t0, t1, t2, highs, busy_hi, changes, seen0;

        seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_dac_code", 32'(dac_code), 32'h0);
        check("rst_adc_result", 32'(adc_result), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(conversion_done), 32'h0);
        check("rst_pwm_out", 32'(pwm_out), 32'h0);

        // 1. Back-to-back conversions of 0xA5 with enable held high
        @(negedge clk);
        target = 8'hA5;
        sb.push_back(8'hA5);
        sb.push_back(8'hA5);
        enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        check("trial_0", 32'(dac_code), 32'(seq[0]));
        check("busy_start", 32'(busy), 32'h1);
        for (int b = 1; b < W; b++) begin
            repeat (STEP) @(posedge clk);
            #1;
            check($sformatf("trial_%0d", b), 32'(dac_code), 32'(seq[b]));
        end
        wait_done("conv1", t1);
        check("latency", 32'(t1 - t0), 32'(LAT));
        wait_done("conv2", t2);
        enable = 1'b0;
        check("period", 32'(t2 - t1), 32'(PERIOD));

        // 2. Boundaries and PWM duty at both ends of the code range
        pulse_enable(8'h00, t0);
        wait_done("conv_zero", t1);
        check("code_zero", 32'(dac_code), 32'h00);
        highs = 0;
        repeat (256) begin
            @(negedge clk);
            if (pwm_out) highs++;
        end
        check("pwm_highs_zero", 32'(highs), 32'd0);

        pulse_enable(8'hFF, t0);
        wait_done("conv_full", t1);
        check("code_full", 32'(dac_code), 32'hFF);
        highs = 0;
        repeat (256) begin
            @(negedge clk);
            if (pwm_out) highs++;
        end
        check("pwm_highs_full", 32'(highs), 32'd255);

        // 3. Single-cycle enable: busy window and held result
        pulse_enable(8'h3C, t0);
        busy_hi = 0;
        for (int i = 0; i < LAT; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy) busy_hi++;
        end
        check("busy_cycles", 32'(busy_hi), 32'(LAT));
        @(posedge clk);
        #1;
        check("pulse_done", 32'(conversion_done), 32'h1);
        check("busy_after_done", 32'(busy), 32'h0);
        seen0 = done_seen;
        repeat (100) @(posedge clk);
        #1;
        check("hold_result", 32'(adc_result), 32'h3C);
        check("hold_busy", 32'(busy), 32'h0);
        check("no_extra_done", 32'(done_seen - seen0), 32'd1);

        // 4. Reset during the 5th settle phase, then re-convert
        @(negedge clk);
        target = 8'h77;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (4 * STEP) @(posedge clk);
        #1;
        check("pre_reset_trial", 32'(dac_code), 32'h78);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_dac_code", 32'(dac_code), 32'h0);
        check("mid_rst_adc_result", 32'(adc_result), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_done", 32'(conversion_done), 32'h0);
        check("mid_rst_pwm", 32'(pwm_out), 32'h0);
        seen0 = done_seen;
        repeat (60) @(posedge clk);
        #1;
        check("no_done_after_reset", 32'(done_seen - seen0), 32'd0);
        pulse_enable(8'h77, t0);
        wait_done("conv_after_reset", t1);
        check("latency_after_reset", 32'(t1 - t0), 32'(LAT));

        // 5. Target change between conversions; result held until next done
        pulse_enable(8'h40, t0);
        wait_done("conv_40", t1);
        pulse_enable(8'hC0, t0);
        changes = 0;
        t1 = -1;
        for (int n = 0; n < BOUND; n++) begin
            if (conversion_done === 1'b1) begin
                t1 = cyc;
                break;
            end
            if (adc_result !== 8'h40) changes++;
            @(posedge clk);
            #1;
        end
        if (t1 < 0) check("conv_C0_timeout", 32'd0, 32'd1);
        check("result_held_40", 32'(changes), 32'd0);
        check("latency_C0", 32'(t1 - t0), 32'(LAT));

        // 6. Mid-scale pattern; latency includes synchronizer cycles when built in
        pulse_enable(8'h5A, t0);
        wait_done("conv_5A", t1);
        check("latency_5A", 32'(t1 - t0), 32'(LAT));

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
